rename_stage: RTL
=================

RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: all state updates on its rising edge.
REQ-002 SHALL have reset `rst`, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have parameters `NUM_ARCH`=32 (architectural registers) and `NUM_PREG`=64 (physical registers); `PREG_W`=$clog2(NUM_PREG).
REQ-004 SHALL have `in_valid` (in, 1): a decoded instruction pair is presented; `in_ready` (out, 1): the pair is accepted this cycle.
REQ-005 SHALL have `rs1_1`, `rs2_1`, `rd_1`, `rs1_2`, `rs2_2`, `rd_2` (in, 5 each) and `RegWrite_1`, `RegWrite_2` (in, 1 each) from decode; slot 1 is older than slot 2.
REQ-006 SHALL have `out_valid` (out, 1) and `out_ready` (in, 1): registered handshake to the dispatch stage.
REQ-007 SHALL have `prs1_x`, `prs2_x`, `prd_x`, `old_prd_x` (out, PREG_W each) and `alloc_x` (out, 1) for x in {1,2}.
REQ-008 SHALL have `free_valid_1`, `free_valid_2` (in, 1) and `free_preg_1`, `free_preg_2` (in, PREG_W): physical registers returned at commit.

Function
REQ-009 SHALL take a transfer when in_valid && in_ready; in_ready = (!out_valid || out_ready) && (free_count >= 2).
REQ-010 SHALL allocate a physical register for slot x only when RegWrite_x && rd_x != 0; alloc_x reflects this.
REQ-011 SHALL set prs1/prs2 from the RAT contents before this pair's updates, with one exception: slot-2 sources equal to rd_1 when alloc_1 is set SHALL take slot 1's new prd.
REQ-012 SHALL set old_prd_x to the RAT mapping of rd_x before this pair's updates; when both slots allocate the same rd, old_prd_2 SHALL equal prd_1.
REQ-013 SHALL, when both slots write the same rd, leave the RAT mapping that rd to prd_2.
REQ-014 SHALL pop free-list entries in order: slot 1 takes the head, slot 2 the next entry (the head if slot 1 does not allocate).
REQ-015 SHALL register all outputs; renamed results appear on outputs one cycle after the transfer.
REQ-016 SHALL hold outputs stable while out_valid && !out_ready; SHALL clear out_valid when out_ready is high and no transfer occurs.
REQ-017 SHALL push freed registers into the free list in the same cycle, free_preg_1 first; pushes and pops in the same cycle SHALL both take effect.
REQ-018 SHALL ignore a free request naming p0; freeing would overflow only on a protocol error, which SHALL trigger a simulation assertion.
REQ-019 SHALL keep x0 permanently mapped to p0 and never allocate p0.
REQ-020 SHALL NOT count registers freed in the current cycle toward in_ready; they become allocatable the next cycle.

Reset
REQ-021 SHALL, on rst, map RAT[i] to p_i for all i, fill the free list with p32..p63 in order (head = p32), set free_count = 32, and clear out_valid.
REQ-022 SHALL, on rst, drive all prs/prd/old_prd outputs to 0 and clear alloc_x.
REQ-023 SHALL let rst override any simultaneous transfer or free request.

Configuration
REQ-024 SHALL, with `RENAME_STALL_CNT_EN` defined, provide output `stall_cycles` (32 bits), cleared on reset, incremented each cycle in_valid && !in_ready, and saturating at all-ones.
REQ-025 SHALL, without `RENAME_STALL_CNT_EN`, omit the port and counter entirely.

Structure
REQ-026 SHALL define NUM_ARCH, NUM_PREG, PREG_W and a `preg_t` typedef in shared package `rename_pkg`.
REQ-027 SHALL implement the free list as sub-module `free_list`: a circular FIFO with 2 pushes and 2 pops per cycle, head/tail pointers and a count.

Verification
REQ-028 After reset, one pair (add x5←x1,x2 / add x6←x5,x3): prs1_2 = 32 (bypass), prd_1 = 32, prd_2 = 33, old_prd_1 = 5, old_prd_2 = 6.
REQ-029 Both slots write x7: prd_1 = 32, prd_2 = 33, old_prd_2 = 32; a later read of x7 yields 33.
REQ-030 An sw pair (RegWrite 0) consumes no free entry, so free_count stays 32; rd = 0 with RegWrite 1 gives alloc = 0.
REQ-031 Allocate 32 registers, then present another pair: in_ready = 0. Free p5 and p6 in one cycle: in_ready = 1 the next cycle, and the next allocations are 5 then 6.
REQ-032 With out_ready held low for 3 cycles: outputs hold, in_ready = 0, and no free-list pop occurs. Assert rst mid-stall: out_valid = 0 and RAT[5] = 5.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared register-rename definitions: architectural/physical register counts,
// physical register index width and the physical register type.
// Imported by rename_stage and free_list.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PREG = 64;
  localparam int PREG_W   = $clog2(NUM_PREG);

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Free physical register list: circular FIFO, up to 2 pushes and 2 pops per cycle.
// Latency: pushed entries are visible at the head/count the cycle after the push.
// Backpressure: none; the caller pops only what o_count covers, and overflow is a protocol error.
// Ports: clk/rst (sync, active-high), i_pop_n (0..2 entries removed from the head),
//        i_push_vld_*/i_push_dat_* (entries appended at the tail, _0 first),
//        o_head_0/o_head_1 (head and next entry), o_count (entries held).
module free_list
  import rename_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = 6,
  parameter int BASE  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_pop_n,
  input  logic             i_push_vld_0,
  input  logic [W-1:0]     i_push_dat_0,
  input  logic             i_push_vld_1,
  input  logic [W-1:0]     i_push_dat_1,
  output logic [W-1:0]     o_head_0,
  output logic [W-1:0]     o_head_1,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [W-1:0]     r_mem [DEPTH];
  ptr_t             r_head;
  ptr_t             r_tail;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_push_n;
  logic [W-1:0]     w_push_first;

  // Wrapping pointer advance; DEPTH need not be a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return ptr_t'(s);
  endfunction

  // Pushes are compacted: a lone push on port 1 lands at the tail.
  assign w_push_n     = {1'b0, i_push_vld_0} + {1'b0, i_push_vld_1};
  assign w_push_first = i_push_vld_0 ? i_push_dat_0 : i_push_dat_1;

  assign o_head_0 = r_mem[r_head];
  assign o_head_1 = r_mem[ptr_add(r_head, 1)];
  assign o_count  = r_count;

  // Reset leaves the list full: head == tail with count == DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= W'(BASE + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(DEPTH);
    end else begin
      if (w_push_n != 2'd0) r_mem[r_tail] <= w_push_first;
      if (w_push_n == 2'd2) r_mem[ptr_add(r_tail, 1)] <= i_push_dat_1;
      r_head  <= ptr_add(r_head, int'(i_pop_n));
      r_tail  <= ptr_add(r_tail, int'(w_push_n));
      r_count <= r_count - CNT_W'(i_pop_n) + CNT_W'(w_push_n);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    int'(i_pop_n) <= int'(r_count));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(r_count) - int'(i_pop_n) + int'(w_push_n)) <= DEPTH);

endmodule

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup, intra-pair bypass, free-list allocation and reclaim.
// Latency: renamed pair appears on registered outputs one cycle after the in_valid/in_ready transfer.
// Backpressure: in_ready drops while the output is held (out_valid && !out_ready) or fewer than 2 free regs.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + rs1/rs2/rd/RegWrite per slot (slot 1 older);
//        out_valid/out_ready + prs1/prs2/prd/old_prd/alloc per slot; free_valid_x/free_preg_x commit returns.
// Optional: RENAME_STALL_CNT_EN adds stall_cycles, a saturating count of cycles with in_valid && !in_ready.
module rename_stage
  import rename_pkg::*;
#(
  parameter int NUM_ARCH = rename_pkg::NUM_ARCH,
  parameter int NUM_PREG = rename_pkg::NUM_PREG,
  parameter int PREG_W   = $clog2(NUM_PREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rs1_1,
  input  logic [4:0]        rs2_1,
  input  logic [4:0]        rd_1,
  input  logic              RegWrite_1,
  input  logic [4:0]        rs1_2,
  input  logic [4:0]        rs2_2,
  input  logic [4:0]        rd_2,
  input  logic              RegWrite_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] prs1_1,
  output logic [PREG_W-1:0] prs2_1,
  output logic [PREG_W-1:0] prd_1,
  output logic [PREG_W-1:0] old_prd_1,
  output logic              alloc_1,
  output logic [PREG_W-1:0] prs1_2,
  output logic [PREG_W-1:0] prs2_2,
  output logic [PREG_W-1:0] prd_2,
  output logic [PREG_W-1:0] old_prd_2,
  output logic              alloc_2,
  input  logic              free_valid_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_valid_2,
  input  logic [PREG_W-1:0] free_preg_2
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int FL_DEPTH = NUM_PREG - NUM_ARCH;
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0]   r_rat [NUM_ARCH];

  logic                r_out_valid;
  logic [PREG_W-1:0]   r_prs1_1, r_prs2_1, r_prd_1, r_old_prd_1;
  logic [PREG_W-1:0]   r_prs1_2, r_prs2_2, r_prd_2, r_old_prd_2;
  logic                r_alloc_1, r_alloc_2;

  logic [PREG_W-1:0]   w_fl_head_0, w_fl_head_1;
  logic [FL_CNT_W-1:0] w_fl_count;
  logic [1:0]          w_pop_n;
  logic                w_push_vld_1, w_push_vld_2;

  logic                w_in_ready, w_fire;
  logic                w_alloc_1, w_alloc_2;
  logic [PREG_W-1:0]   w_prd_1, w_prd_2;
  logic [PREG_W-1:0]   w_prs1_2, w_prs2_2, w_old_prd_2;

  // Frees arriving this cycle are not counted: w_fl_count is the registered count.
  assign w_in_ready = (!r_out_valid || out_ready) && (w_fl_count >= FL_CNT_W'(2));
  assign w_fire     = in_valid && w_in_ready;

  assign w_alloc_1  = RegWrite_1 && (rd_1 != 5'd0);
  assign w_alloc_2  = RegWrite_2 && (rd_2 != 5'd0);

  // Slot 2 takes the head when slot 1 does not allocate.
  assign w_prd_1 = w_alloc_1 ? w_fl_head_0 : '0;
  assign w_prd_2 = !w_alloc_2 ? '0 : (w_alloc_1 ? w_fl_head_1 : w_fl_head_0);

  assign w_pop_n = w_fire ? ({1'b0, w_alloc_1} + {1'b0, w_alloc_2}) : 2'd0;

  // Slot 2 must see slot 1's new mapping; alloc_1 implies rd_1 != 0, so x0 is never bypassed.
  assign w_prs1_2    = (w_alloc_1 && rs1_2 == rd_1) ? w_prd_1 : r_rat[rs1_2];
  assign w_prs2_2    = (w_alloc_1 && rs2_2 == rd_1) ? w_prd_1 : r_rat[rs2_2];
  assign w_old_prd_2 = (w_alloc_1 && w_alloc_2 && rd_2 == rd_1) ? w_prd_1 : r_rat[rd_2];

  // p0 backs x0 forever and must never enter the free list.
  assign w_push_vld_1 = free_valid_1 && (free_preg_1 != '0);
  assign w_push_vld_2 = free_valid_2 && (free_preg_2 != '0);

  free_list #(
    .DEPTH (FL_DEPTH),
    .W     (PREG_W),
    .BASE  (NUM_ARCH),
    .CNT_W (FL_CNT_W)
  ) u_free_list (
    .clk          (clk),
    .rst          (rst),
    .i_pop_n      (w_pop_n),
    .i_push_vld_0 (w_push_vld_1),
    .i_push_dat_0 (free_preg_1),
    .i_push_vld_1 (w_push_vld_2),
    .i_push_dat_1 (free_preg_2),
    .o_head_0     (w_fl_head_0),
    .o_head_1     (w_fl_head_1),
    .o_count      (w_fl_count)
  );

  // Slot 2's write is issued last so it wins when both slots target the same rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) r_rat[i] <= PREG_W'(i);
    end else if (w_fire) begin
      if (w_alloc_1) r_rat[rd_1] <= w_prd_1;
      if (w_alloc_2) r_rat[rd_2] <= w_prd_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_prs1_1    <= '0;
      r_prs2_1    <= '0;
      r_prd_1     <= '0;
      r_old_prd_1 <= '0;
      r_alloc_1   <= 1'b0;
      r_prs1_2    <= '0;
      r_prs2_2    <= '0;
      r_prd_2     <= '0;
      r_old_prd_2 <= '0;
      r_alloc_2   <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_prs1_1    <= r_rat[rs1_1];
      r_prs2_1    <= r_rat[rs2_1];
      r_prd_1     <= w_prd_1;
      r_old_prd_1 <= r_rat[rd_1];
      r_alloc_1   <= w_alloc_1;
      r_prs1_2    <= w_prs1_2;
      r_prs2_2    <= w_prs2_2;
      r_prd_2     <= w_prd_2;
      r_old_prd_2 <= w_old_prd_2;
      r_alloc_2   <= w_alloc_2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign prs1_1    = r_prs1_1;
  assign prs2_1    = r_prs2_1;
  assign prd_1     = r_prd_1;
  assign old_prd_1 = r_old_prd_1;
  assign alloc_1   = r_alloc_1;
  assign prs1_2    = r_prs1_2;
  assign prs2_2    = r_prs2_2;
  assign prd_2     = r_prd_2;
  assign old_prd_2 = r_old_prd_2;
  assign alloc_2   = r_alloc_2;

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (in_valid && !w_in_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
